// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
//  Module   : game_timer
//  Purpose  : Countdown game clock. A prescaler divides clk down to one game
//             second; the remaining time is kept both in binary and as two
//             BCD digits that are updated incrementally (no divider).
//             Supports start/pause/resume, restart, bonus time with
//             saturation at 99, and a one-cycle time_up pulse on expiry.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, pause        - start/resume pulse, pause-toggle pulse
//             restart, bonus      - reload-to-idle pulse, add-time pulse
//             game_duration[6:0]  - remaining seconds (binary, 0..99)
//             digit_10s/digit_1s  - BCD tens/units of game_duration
//             running, expired    - state flags
//             time_up             - one-cycle pulse after expiry edge
//  Revision : 1.0  - initial release
// ============================================================================
module game_timer #(
    parameter int TICKS_PER_SECOND = 25000000,
    parameter int START_SECONDS    = 99,
    parameter int BONUS_SECONDS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    input  logic       bonus,
    output logic [6:0] game_duration,
    output logic [3:0] digit_10s,
    output logic [3:0] digit_1s,
    output logic       running,
    output logic       time_up,
    output logic       expired
);

    localparam int               c_PRESC_W  = (TICKS_PER_SECOND > 2) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICKS_PER_SECOND - 1);
    localparam logic [6:0]       c_START_VAL = 7'(START_SECONDS);
    localparam logic [3:0]       c_START_10  = 4'(START_SECONDS / 10);
    localparam logic [3:0]       c_START_1   = 4'(START_SECONDS % 10);
    localparam logic [3:0]       c_BONUS_10  = 4'(BONUS_SECONDS / 10);
    localparam logic [3:0]       c_BONUS_1   = 4'(BONUS_SECONDS % 10);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_PRESC_W-1:0]   r_presc;

    // Bonus-adjusted value (binary and BCD)
    logic [7:0] w_bin_sum;
    logic [4:0] w_u_sum;
    logic       w_u_carry;
    logic [3:0] w_u_adj;
    logic [3:0] w_t_sum;
    logic [6:0] w_bon_val;
    logic [3:0] w_bon_10;
    logic [3:0] w_bon_1;

    // Value the decrement starts from, and the decremented result
    logic [6:0] w_base_val;
    logic [3:0] w_base_10;
    logic [3:0] w_base_1;
    logic [6:0] w_dec_val;
    logic [3:0] w_dec_10;
    logic [3:0] w_dec_1;

    logic       w_wrap;

    always_comb begin
        w_wrap    = (r_presc == c_PRESC_MAX);

        // BCD add of the bonus constant alongside the binary add. The tens
        // sum may overflow its 4 bits, but only when the binary sum exceeds
        // 99, in which case the saturated digits are used instead.
        w_bin_sum = {1'b0, game_duration} + 8'(BONUS_SECONDS);
        w_u_sum   = {1'b0, digit_1s} + {1'b0, c_BONUS_1};
        w_u_carry = (w_u_sum > 5'd9);
        w_u_adj   = w_u_carry ? 4'(w_u_sum - 5'd10) : w_u_sum[3:0];
        w_t_sum   = digit_10s + c_BONUS_10 + {3'b000, w_u_carry};

        if (w_bin_sum > 8'd99) begin
            w_bon_val = 7'd99;
            w_bon_10  = 4'd9;
            w_bon_1   = 4'd9;
        end else begin
            w_bon_val = w_bin_sum[6:0];
            w_bon_10  = w_t_sum;
            w_bon_1   = w_u_adj;
        end

        // Bonus is applied before a coincident decrement.
        if (bonus) begin
            w_base_val = w_bon_val;
            w_base_10  = w_bon_10;
            w_base_1   = w_bon_1;
        end else begin
            w_base_val = game_duration;
            w_base_10  = digit_10s;
            w_base_1   = digit_1s;
        end

        // BCD decrement: units borrow 0 -> 9 from the tens digit. The base
        // is always >= 1 while running, so tens never underflows.
        w_dec_val = w_base_val - 7'd1;
        if (w_base_1 == 4'd0) begin
            w_dec_1  = 4'd9;
            w_dec_10 = w_base_10 - 4'd1;
        end else begin
            w_dec_1  = w_base_1 - 4'd1;
            w_dec_10 = w_base_10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state       <= ST_IDLE;
            r_presc       <= '0;
            game_duration <= c_START_VAL;
            digit_10s     <= c_START_10;
            digit_1s      <= c_START_1;
            running       <= 1'b0;
            time_up       <= 1'b0;
            expired       <= 1'b0;
        end else begin
            time_up <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUNNING;
                        running <= 1'b1;
                    end
                end

                ST_RUNNING: begin
                    if (pause) begin
                        // Pause wins over a wrap: prescaler frozen as-is.
                        r_state <= ST_PAUSED;
                        running <= 1'b0;
                        if (bonus) begin
                            game_duration <= w_bon_val;
                            digit_10s     <= w_bon_10;
                            digit_1s      <= w_bon_1;
                        end
                    end else if (w_wrap) begin
                        r_presc       <= '0;
                        game_duration <= w_dec_val;
                        digit_10s     <= w_dec_10;
                        digit_1s      <= w_dec_1;
                        if (w_dec_val == 7'd0) begin
                            r_state <= ST_EXPIRED;
                            running <= 1'b0;
                            expired <= 1'b1;
                            time_up <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + c_PRESC_W'(1);
                        if (bonus) begin
                            game_duration <= w_bon_val;
                            digit_10s     <= w_bon_10;
                            digit_1s      <= w_bon_1;
                        end
                    end
                end

                ST_PAUSED: begin
                    if (bonus) begin
                        game_duration <= w_bon_val;
                        digit_10s     <= w_bon_10;
                        digit_1s      <= w_bon_1;
                    end
                    if (pause || start) begin
                        r_state <= ST_RUNNING;
                        running <= 1'b1;
                    end
                end

                ST_EXPIRED: begin
                    // Hold at zero until restart or rst.
                end

                default: begin
                    r_state <= ST_IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_timer
//  Purpose  : Directed self-checking bench for game_timer with
//             TICKS_PER_SECOND=4, START_SECONDS=12, BONUS_SECONDS=10.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_game_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       restart;
    logic       bonus;
    logic [6:0] game_duration;
    logic [3:0] digit_10s;
    logic [3:0] digit_1s;
    logic       running;
    logic       time_up;
    logic       expired;

    int n_cmp;
    int n_bad;

    game_timer #(
        .TICKS_PER_SECOND (4),
        .START_SECONDS    (12),
        .BONUS_SECONDS    (10)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pause         (pause),
        .restart       (restart),
        .bonus         (bonus),
        .game_duration (game_duration),
        .digit_10s     (digit_10s),
        .digit_1s      (digit_1s),
        .running       (running),
        .time_up       (time_up),
        .expired       (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges; inputs change and outputs are sampled 1 time unit
    // after each rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start;   start   = 1'b1; cyc(1); start   = 1'b0; endtask
    task automatic do_pause;   pause   = 1'b1; cyc(1); pause   = 1'b0; endtask
    task automatic do_restart; restart = 1'b1; cyc(1); restart = 1'b0; endtask
    task automatic do_bonus;   bonus   = 1'b1; cyc(1); bonus   = 1'b0; endtask

    task automatic chk_val(input string tag, input int v, input int d10, input int d1);
        chk({tag, "_dur"}, int'(game_duration), v);
        chk({tag, "_d10"}, int'(digit_10s), d10);
        chk({tag, "_d1"},  int'(digit_1s),  d1);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        pause   = 1'b0;
        restart = 1'b0;
        bonus   = 1'b0;

        // Reset state
        cyc(2);
        rst = 1'b0;
        chk_val("reset", 12, 1, 2);
        chk("reset_running", int'(running), 0);
        chk("reset_time_up", int'(time_up), 0);
        chk("reset_expired", int'(expired), 0);

        // Start and first decrements
        do_start;
        chk("start_running", int'(running), 1);
        cyc(3);
        chk("pre_wrap_dur", int'(game_duration), 12);
        cyc(1);
        chk_val("first_dec", 11, 1, 1);
        cyc(4);
        chk_val("dec_10", 10, 1, 0);
        cyc(4);
        chk_val("borrow_9", 9, 0, 9);

        // Pause on the wrap cycle: no decrement, prescaler held
        cyc(3);
        do_pause;
        chk("pause_wrap_dur", int'(game_duration), 9);
        chk("pause_running", int'(running), 0);
        cyc(20);
        chk("paused_hold_dur", int'(game_duration), 9);
        do_pause;
        chk("resume_running", int'(running), 1);
        chk("resume_dur", int'(game_duration), 9);
        cyc(1);
        chk_val("resume_dec", 8, 0, 8);

        // Restart while paused at 5
        do_restart;
        do_start;
        cyc(28);
        chk("run_to_5", int'(game_duration), 5);
        do_pause;
        chk("paused_at_5", int'(game_duration), 5);
        do_restart;
        chk_val("restart_paused", 12, 1, 2);
        chk("restart_running", int'(running), 0);

        // Bonus while paused, up to 95 then saturate at 99
        do_start;
        cyc(28);
        do_pause;
        repeat (9) do_bonus;
        chk_val("bonus_95", 95, 9, 5);
        do_bonus;
        chk_val("bonus_sat", 99, 9, 9);

        // Value 1 with bonus coincident with the wrap -> 10, no expiry
        do_restart;
        do_start;
        cyc(44);
        chk("run_to_1", int'(game_duration), 1);
        cyc(3);
        do_bonus;
        chk_val("bonus_wrap", 10, 1, 0);
        chk("bonus_wrap_time_up", int'(time_up), 0);
        chk("bonus_wrap_expired", int'(expired), 0);
        chk("bonus_wrap_running", int'(running), 1);

        // Run to expiry
        cyc(39);
        chk("pre_expiry_dur", int'(game_duration), 1);
        chk("pre_expiry_time_up", int'(time_up), 0);
        cyc(1);
        chk_val("expiry", 0, 0, 0);
        chk("expiry_time_up", int'(time_up), 1);
        chk("expiry_expired", int'(expired), 1);
        chk("expiry_running", int'(running), 0);
        cyc(1);
        chk("time_up_one_cycle", int'(time_up), 0);
        chk("expired_hold", int'(expired), 1);
        start = 1'b1;
        bonus = 1'b1;
        cyc(1);
        start = 1'b0;
        bonus = 1'b0;
        cyc(1);
        chk_val("expired_ignore", 0, 0, 0);
        chk("expired_ignore_running", int'(running), 0);
        chk("expired_ignore_expired", int'(expired), 1);

        // rst mid-RUNNING
        do_restart;
        do_start;
        cyc(6);
        chk("mid_run_dur", int'(game_duration), 11);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_val("rst_mid_run", 12, 1, 2);
        chk("rst_mid_run_running", int'(running), 0);
        chk("rst_mid_run_expired", int'(expired), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SECOND, default 25000000: clk cycles per game second, legal range 2..2^26.
REQ-002 SHALL have parameter START_SECONDS, default 99: reload value, legal range 1..99.
REQ-003 SHALL have parameter BONUS_SECONDS, default 10: seconds added per bonus, legal range 1..99.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic SHALL be rising-edge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that starts or resumes counting.
REQ-007 SHALL have port pause, input, 1: one-cycle pulse that toggles between RUNNING and PAUSED.
REQ-008 SHALL have port restart, input, 1: one-cycle pulse that reloads START_SECONDS and returns to IDLE.
REQ-009 SHALL have port bonus, input, 1: one-cycle pulse that adds BONUS_SECONDS.
REQ-010 SHALL have port game_duration, output, 7: remaining seconds in binary, 0..99.
REQ-011 SHALL have port digit_10s, output, 4: tens digit of game_duration in BCD.
REQ-012 SHALL have port digit_1s, output, 4: units digit of game_duration in BCD.
REQ-013 SHALL have port running, output, 1: high while state is RUNNING.
REQ-014 SHALL have port time_up, output, 1: one-cycle pulse on expiry.
REQ-015 SHALL have port expired, output, 1: high while state is EXPIRED.

Function
REQ-016 SHALL implement four states: IDLE, RUNNING, PAUSED, EXPIRED.
REQ-017 SHALL, in IDLE, hold game_duration = START_SECONDS and move to RUNNING one cycle after start, with the prescaler cleared to 0.
REQ-018 SHALL, in RUNNING, increment the prescaler every cycle: at TICKS_PER_SECOND-1 it wraps to 0 and game_duration decrements by 1 in the same edge.
REQ-019 SHALL keep digit_10s/digit_1s registered and equal to game_duration/10 and game_duration%10 on every cycle, with no divider: BCD decrement borrows 0 -> 9 in the units digit.
REQ-020 SHALL, when a decrement takes game_duration from 1 to 0, enter EXPIRED on that edge and assert time_up for exactly that following cycle.
REQ-021 SHALL, on pause in RUNNING, enter PAUSED with the prescaler frozen; pause or start in PAUSED SHALL return to RUNNING with the prescaler resumed from its held value.
REQ-022 SHALL give pause priority over a same-cycle prescaler wrap: no decrement occurs and the prescaler holds at TICKS_PER_SECOND-1.
REQ-023 SHALL ignore pause in IDLE and EXPIRED, and SHALL ignore start in RUNNING and EXPIRED.
REQ-024 SHALL, on bonus in RUNNING or PAUSED, add BONUS_SECONDS saturating at 99, with BCD digits updated consistently.
REQ-025 SHALL apply bonus before decrement when both fall in one cycle: result = min(99, value+BONUS)-1; expiry SHALL NOT occur on that cycle.
REQ-026 SHALL ignore bonus in IDLE and EXPIRED.
REQ-027 SHALL, on restart in any state, go to IDLE, reload START_SECONDS, clear the prescaler and deassert time_up; restart SHALL override every other input that cycle.
REQ-028 SHALL, in EXPIRED, hold game_duration = 0, digits 0/0 and expired = 1 until restart or rst.
REQ-029 SHALL drive every output from a register, so that outputs update one cycle after the causing edge and there are no combinational input-to-output paths.

Reset
REQ-030 SHALL, with rst high at a clk edge, set state IDLE, prescaler 0, game_duration = START_SECONDS, digits = BCD(START_SECONDS), and running/time_up/expired = 0.
REQ-031 SHALL give rst priority over all inputs, including reset mid-RUNNING and reset on the cycle time_up is asserted.

Verification (TICKS_PER_SECOND=4, START_SECONDS=12, BONUS_SECONDS=10)
REQ-032 SHALL cover: rst, then start -> running=1 next cycle; game_duration 12 -> 11 after 4 cycles; 10 -> 9 shows digits 1/0 -> 0/9.
REQ-033 SHALL cover: run to expiry -> game_duration 0, time_up high exactly 1 cycle, expired=1; start and bonus afterwards produce no change.
REQ-034 SHALL cover: pause on the wrap cycle -> no decrement; 20 idle cycles, value unchanged; pause again -> decrement 1 cycle later.
REQ-035 SHALL cover: value 95, bonus -> 99 (saturate); value 1, bonus coincident with wrap -> 10, digits 1/0, no time_up.
REQ-036 SHALL cover: restart while PAUSED at 5 -> IDLE, game_duration 12, running=0; rst asserted mid-RUNNING -> reset values next cycle.
